// File: rtl/areg_wr_arb.sv
// Round-robin arbiter for the accumulate register file write port.
// A requester holds the port across a burst until it presents last=1.
`ifndef BITNESS
`define BITNESS 32
`endif

module areg_wr_arb #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = `BITNESS
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        hold,
    input  logic [NREQ-1:0]             req_valid,
    output logic [NREQ-1:0]             req_ready,
    input  logic [NREQ-1:0]             req_y,
    input  logic [NREQ*4-1:0]           req_wa,
    input  logic [NREQ*WIDTH-1:0]       req_wval,
    input  logic [NREQ-1:0]             req_last,
    output logic                        w,
    output logic                        y,
    output logic [3:0]                  wa,
    output logic [WIDTH-1:0]            wval,
    output logic [$clog2(NREQ)-1:0]     owner,
    output logic                        locked
);
    localparam int unsigned IW = $clog2(NREQ);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t        state, state_n;
    logic [IW-1:0] rr_ptr, rr_n, owner_n, gidx, cand;
    logic          acc;

    // Grant selection: locked owner only, else first valid scanning from rr_ptr
    always_comb begin
        req_ready = '0;
        gidx      = owner;
        cand      = '0;
        acc       = 1'b0;
        if (!rst && !hold) begin
            if (state == LOCK) begin
                if (req_valid[owner]) begin
                    req_ready[owner] = 1'b1;
                    acc              = 1'b1;
                end
            end else begin
                for (int unsigned k = 0; k < NREQ; k++) begin
                    cand = IW'((32'(rr_ptr) + k) % NREQ);
                    if (!acc && req_valid[cand]) begin
                        acc             = 1'b1;
                        gidx            = cand;
                        req_ready[cand] = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        state_n = state;
        rr_n    = rr_ptr;
        owner_n = owner;
        if (acc) begin
            owner_n = gidx;
            if (req_last[gidx]) begin
                state_n = IDLE;
                rr_n    = (32'(gidx) == NREQ - 1) ? '0 : gidx + 1'b1;
            end else begin
                state_n = LOCK;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            rr_ptr <= '0;
            owner  <= '0;
        end else begin
            state  <= state_n;
            rr_ptr <= rr_n;
            owner  <= owner_n;
        end
    end

    // Registered write port; fields hold their last value when no beat is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w    <= 1'b0;
            y    <= 1'b0;
            wa   <= '0;
            wval <= '0;
        end else begin
            w <= acc;
            if (acc) begin
                y    <= req_y[gidx];
                wa   <= req_wa[gidx*4 +: 4];
                wval <= req_wval[gidx*WIDTH +: WIDTH];
            end
        end
    end

    assign locked = (state == LOCK);

endmodule

// File: tb/tb_areg_wr_arb.sv
// Self-checking bench for areg_wr_arb: vector table, corner sequences and
// randomized traffic against a behavioural arbitration model.
module tb_areg_wr_arb;
    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           hold;
    logic [N-1:0]   req_valid, req_ready, req_y, req_last;
    logic [N*4-1:0] req_wa;
    logic [N*W-1:0] req_wval;
    logic           w, y, locked;
    logic [3:0]     wa;
    logic [W-1:0]   wval;
    logic [1:0]     owner;

    always #5 clk = ~clk;

    areg_wr_arb #(.NREQ(N), .WIDTH(W)) dut (
        .clk(clk), .rst(rst), .hold(hold),
        .req_valid(req_valid), .req_ready(req_ready), .req_y(req_y),
        .req_wa(req_wa), .req_wval(req_wval), .req_last(req_last),
        .w(w), .y(y), .wa(wa), .wval(wval), .owner(owner), .locked(locked)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Model: lock owner (-1 = none), round-robin start, last accepted beat
    int           m_lock, m_rr, m_owner;
    logic         m_w, m_y;
    logic [3:0]   m_wa;
    logic [W-1:0] m_wval;

    typedef struct {
        logic       hold;
        logic [3:0] valid, last, ready;
        logic       w;
        logic [3:0] wa;
        logic [1:0] owner;
        logic       locked;
    } vec_t;
    vec_t tbl[13];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_lock = -1; m_rr = 0; m_owner = 0;
        m_w = 1'b0; m_y = 1'b0; m_wa = '0; m_wval = '0;
    endtask

    function automatic int model_grant();
        if (hold) return -1;
        if (m_lock >= 0) return req_valid[m_lock] ? m_lock : -1;
        for (int k = 0; k < N; k++)
            if (req_valid[(m_rr + k) % N]) return (m_rr + k) % N;
        return -1;
    endfunction

    task automatic set_fixed_fields();
        req_wa   = {4'd7, 4'd6, 4'd5, 4'd4};
        req_wval = {32'd103, 32'd102, 32'd101, 32'd100};
        req_y    = 4'b1010;
    endtask

    task automatic drive(input logic h, input logic [N-1:0] v, input logic [N-1:0] l);
        @(negedge clk);
        hold = h; req_valid = v; req_last = l;
        #1;
    endtask

    // Compare against the model, then advance the model across the next posedge
    task automatic model_cycle(input string tag);
        int g;
        logic [N-1:0] er;
        g  = model_grant();
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        chk({tag, " ready"}, req_ready, er);
        chk({tag, " w"}, w, m_w);
        chk({tag, " y"}, y, m_y);
        chk({tag, " wa"}, wa, m_wa);
        chk({tag, " wval"}, wval, m_wval);
        chk({tag, " owner"}, owner, m_owner);
        chk({tag, " locked"}, locked, m_lock >= 0);
        @(posedge clk);
        if (g >= 0) begin
            m_w = 1'b1; m_y = req_y[g]; m_wa = req_wa[g*4 +: 4];
            m_wval = req_wval[g*W +: W]; m_owner = g;
            if (req_last[g]) begin m_lock = -1; m_rr = (g + 1) % N; end
            else m_lock = g;
        end else begin
            m_w = 1'b0;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; hold = 1'b0; req_valid = '1; req_last = '1;
        #1;
        chk("rst ready", req_ready, 0);
        chk("rst w", w, 0);
        chk("rst locked", locked, 0);
        chk("rst owner", owner, 0);
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        rst = 1'b1; hold = 1'b0; req_valid = '0; req_last = '0;
        set_fixed_fields();
        model_reset();

        //          hold valid last  ready w  wa    own   lck
        tbl[0]  = '{0, 4'hF, 4'hF, 4'h1, 0, 4'd0, 2'd0, 0};
        tbl[1]  = '{0, 4'hF, 4'hF, 4'h2, 1, 4'd4, 2'd0, 0};
        tbl[2]  = '{0, 4'hF, 4'hF, 4'h4, 1, 4'd5, 2'd1, 0};
        tbl[3]  = '{1, 4'hF, 4'hF, 4'h0, 1, 4'd6, 2'd2, 0};
        tbl[4]  = '{1, 4'hF, 4'hF, 4'h0, 0, 4'd6, 2'd2, 0};
        tbl[5]  = '{0, 4'hF, 4'hF, 4'h8, 0, 4'd6, 2'd2, 0};
        tbl[6]  = '{0, 4'hF, 4'hF, 4'h1, 1, 4'd7, 2'd3, 0};
        tbl[7]  = '{0, 4'h4, 4'h0, 4'h4, 1, 4'd4, 2'd0, 0};
        tbl[8]  = '{0, 4'hD, 4'h0, 4'h4, 1, 4'd6, 2'd2, 1};
        tbl[9]  = '{0, 4'hD, 4'h4, 4'h4, 1, 4'd6, 2'd2, 1};
        tbl[10] = '{0, 4'h9, 4'hF, 4'h8, 1, 4'd6, 2'd2, 0};
        tbl[11] = '{0, 4'h0, 4'h0, 4'h0, 1, 4'd7, 2'd3, 0};
        tbl[12] = '{0, 4'h0, 4'h0, 4'h0, 0, 4'd7, 2'd3, 0};

        apply_reset();
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].hold, tbl[i].valid, tbl[i].last);
            chk($sformatf("tbl%0d ready", i), req_ready, tbl[i].ready);
            chk($sformatf("tbl%0d w", i), w, tbl[i].w);
            chk($sformatf("tbl%0d wa", i), wa, tbl[i].wa);
            chk($sformatf("tbl%0d owner", i), owner, tbl[i].owner);
            chk($sformatf("tbl%0d locked", i), locked, tbl[i].locked);
        end

        // Owner goes idle inside a lock: nobody else may be granted
        apply_reset();
        drive(0, 4'b0010, 4'b0000); model_cycle("idle_lock start");
        for (int i = 0; i < 4; i++) begin
            drive(0, 4'b0001, 4'b0001); model_cycle("idle_lock wait");
            chk("idle_lock blocked", req_ready, 0);
        end
        drive(0, 4'b0011, 4'b0010); model_cycle("idle_lock end");
        drive(0, 4'b0001, 4'b0001); model_cycle("idle_lock after");
        chk("idle_lock req0 granted", req_ready, 4'b0001);

        // Asynchronous reset during a burst with a write pending
        apply_reset();
        drive(0, 4'b0100, 4'b0000); model_cycle("rst_burst beat");
        #2;
        rst = 1'b1;
        #1;
        chk("rst_burst w", w, 0);
        chk("rst_burst locked", locked, 0);
        chk("rst_burst owner", owner, 0);
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        drive(0, 4'b1111, 4'b1111); model_cycle("rst_burst resume");
        chk("rst_burst first grant", req_ready, 4'b0001);

        // Single requester repeatedly granted
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            drive(0, 4'b1000, 4'b1000); model_cycle("single");
            chk("single ready", req_ready, 4'b1000);
        end

        // Randomized traffic against the model
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            hold      = ($urandom_range(0, 7) == 0);
            req_valid = N'($urandom);
            req_last  = N'($urandom) | N'($urandom);
            req_y     = N'($urandom);
            req_wa    = ($urandom);
            for (int k = 0; k < N; k++) req_wval[k*W +: W] = $urandom;
            #1;
            model_cycle("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
